// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared defaults, width helpers and error-cause codes for the fifo write arbiter.
package fifo_arb_pkg;
    localparam int NREQ_D  = 4;
    localparam int WIDTH_D = 8;
    localparam int DEPTH_D = 16;
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int iw_of(input int nreq);
        return $clog2(nreq);
    endfunction
    typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UDF} err_cause_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker; searches upward starting just after ptr.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_raw,
    output logic [IW-1:0]   idx
);
    logic          w_found;
    logic [IW-1:0] w_j;
    always_comb begin
        gnt_raw = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IW'((int'(ptr) + 1 + k) % NREQ);
            if (!w_found && req[w_j]) begin
                w_found      = 1'b1;
                gnt_raw[w_j] = 1'b1;
                idx          = w_j;
            end
        end
    end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin write arbiter feeding one fifo through a registered push stage,
// with a credit counter that tracks free slots including pushes still in flight.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_D,
    parameter int WIDTH = WIDTH_D,
    parameter int DEPTH = DEPTH_D,
    parameter int CW    = cw_of(DEPTH),
    parameter int IW    = iw_of(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  fifo_push,
    output logic [WIDTH-1:0]      fifo_wd,
    input  logic                  fifo_pop,
    input  logic                  fifo_full,
    output logic [CW-1:0]         credits,
    output logic [IW-1:0]         last_id,
    output logic                  err
);
    logic [IW-1:0]    r_ptr, r_last, w_idx;
    logic [NREQ-1:0]  w_gnt_raw;
    logic             r_push, r_err, w_g, w_udf;
    logic [WIDTH-1:0] r_wd;
    logic [CW-1:0]    r_credits, w_credits_nxt;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .gnt_raw (w_gnt_raw),
        .idx     (w_idx)
    );

    assign gnt           = (r_credits != '0) ? w_gnt_raw : '0;
    assign w_g           = |gnt;
    // A pop with every slot free is bogus: flag it and do not count it back.
    assign w_udf         = fifo_pop && (r_credits == CW'(DEPTH));
    assign w_credits_nxt = r_credits - CW'(w_g) + CW'(fifo_pop && !w_udf);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_push    <= 1'b0;
            r_wd      <= '0;
            r_last    <= '0;
            r_ptr     <= IW'(NREQ - 1);
            r_credits <= CW'(DEPTH);
            r_err     <= 1'b0;
        end else begin
            r_push    <= w_g;
            r_credits <= w_credits_nxt;
            if (w_g) begin
                r_wd   <= wdata[int'(w_idx)*WIDTH +: WIDTH];
                r_last <= w_idx;
                r_ptr  <= w_idx;
            end
            if (w_udf || (r_push && fifo_full))
                r_err <= 1'b1;
        end
    end

    assign fifo_push = r_push;
    assign fifo_wd   = r_wd;
    assign credits   = r_credits;
    assign last_id   = r_last;
    assign err       = r_err;
endmodule
